dc_svc: RTL and testbench
=========================

DC_SVC -- requirements
Module: dc_svc

Interface
REQ-001 SHALL have parameter TOUT_LIMIT, default 64, meaning the number of pin_mce_p ticks without reply before bus timeout (legal range 2..255).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth for asynchronous inputs (legal range 2..3).
REQ-003 SHALL have ports:
- pin_clk  in  1  main clock.
- pin_rst_n  in  1  reset, asynchronous, active-low.
- pin_mce_p  in  1  master rising-edge enable.
- pin_mce_n  in  1  master falling-edge enable.
- pin_irq  in  4  async IRQ[7:4], active-high; bit 3 = IRQ7.
- pin_evnt  in  1  async line-clock event.
- pin_aclo_n  in  1  async power-down, active-low.
- pin_dclo_n  in  1  async DC-low, active-low (1 = OK).
- pin_halt  in  1  async halt request, active-high.
- pin_cce_n, pin_abt_n, pin_par_n  in  1 each  control-chip error, MMU abort, parity error; synchronous, active-low.
- pin_sync, pin_rply  in  1 each  bus cycle active, slave reply.
- pin_tout  in  1  external timeout; used only without DC_SVC_TOUT_EN.
- pin_evnt_clr, pin_tout_clr  in  1 each  microcode acknowledge pulses.
- pin_svc  out  13  service status word feeding the control chip.

Function
REQ-004 SHALL pass pin_irq, pin_evnt, pin_aclo_n, pin_dclo_n and pin_halt through SYNC_STAGES flops clocked every pin_clk.
REQ-005 SHALL set the event latch on a synchronized pin_evnt 0->1 edge, and SHALL clear it on pin_evnt_clr qualified by pin_mce_n; if set and clear coincide, set SHALL win.
REQ-006 SHALL implement the timeout FSM IDLE/COUNT/EXPIRED, advancing only on pin_mce_p.
REQ-007 IDLE->COUNT SHALL occur on pin_sync=1 & pin_rply=0, loading the 8-bit counter with 1.
REQ-008 In COUNT, the counter SHALL increment each pin_mce_p; pin_rply=1 or pin_sync=0 SHALL return the FSM to IDLE; counter==TOUT_LIMIT SHALL go to EXPIRED and set the timeout latch.
REQ-009 EXPIRED->IDLE SHALL occur on pin_sync=0; the timeout latch SHALL clear only on pin_tout_clr qualified by pin_mce_n, with set winning a tie.
REQ-010 The counter SHALL saturate at TOUT_LIMIT and never wrap.
REQ-011 SHALL register pin_svc only on pin_mce_n, so it is stable across the consumer's pin_mce_p sample.
REQ-012 pin_svc mapping: [12] event latch, [11:8] sync IRQ4..IRQ7, [7] sync aclo_n, [6] constant 0, [5] sync halt, [4] pin_cce_n, [3] pin_abt_n, [2] pin_par_n, [1] timeout latch, [0] sync dclo_n.
REQ-013 Update latency SHALL be at most SYNC_STAGES pin_clk cycles plus the next pin_mce_n.

Reset
REQ-014 On pin_rst_n=0, asynchronously: synchronizers SHALL load their inactive levels (irq/evnt/halt 0, aclo_n/dclo_n 1); latches 0; FSM IDLE; counter 0; pin_svc = 13'h0095.
REQ-015 Reset asserted mid-COUNT SHALL abort the count without setting the timeout latch.
REQ-016 Reset release SHALL produce no false event edge, even if pin_evnt is already high.

Configuration
REQ-017 With DC_SVC_TOUT_EN defined, the timeout FSM and counter SHALL be built as specified.
REQ-018 Without DC_SVC_TOUT_EN, the FSM and counter SHALL be omitted; pin_tout SHALL set the timeout latch, with the same clear rule.

Structure
REQ-019 A shared package dc_svc_pkg SHALL hold the FSM state enum, the svc bit-index constants and the reset word 13'h0095.
REQ-020 A sub-module dc_sync (parameterized-depth synchronizer with reset value) SHALL be instantiated once per async input.

Verification
REQ-021 Reset: pin_rst_n low with all inputs idle -> pin_svc=13'h0095; release with pin_evnt=1 -> pin_svc[12] stays 0.
REQ-022 Event: pin_evnt 0->1 -> pin_svc[12]=1 within 3 clocks plus pin_mce_n; pin_evnt_clr coincident with a new edge -> bit stays 1.
REQ-023 Timeout: pin_sync=1, pin_rply=0 for 64 pin_mce_p ticks -> pin_svc[1]=1; reply at tick 63 -> pin_svc[1] stays 0.
REQ-024 IRQ: pin_irq=4'b1000 -> pin_svc[11:8]=4'b1000; pin_aclo_n=0 -> pin_svc[7]=0.
REQ-025 Stability: toggle pin_halt between pin_mce_n pulses -> pin_svc changes only on pin_mce_n.
REQ-026 Macro off: pin_tout=1 -> pin_svc[1]=1; pin_tout_clr -> pin_svc[1]=0.

Source files
------------

// File: rtl/dc_svc_pkg.sv
// Shared definitions for the dc_svc service-status block: timeout FSM states,
// pin_svc bit positions and the reset value of the status word.
package dc_svc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StExpired
  } tout_st_e;

  localparam int unsigned SvcWidth = 13;

  localparam int unsigned SvcEvnt  = 12;
  localparam int unsigned SvcIrqLo = 8;
  localparam int unsigned SvcAclo  = 7;
  localparam int unsigned SvcZero  = 6;
  localparam int unsigned SvcHalt  = 5;
  localparam int unsigned SvcCce   = 4;
  localparam int unsigned SvcAbt   = 3;
  localparam int unsigned SvcPar   = 2;
  localparam int unsigned SvcTout  = 1;
  localparam int unsigned SvcDclo  = 0;

  localparam logic [SvcWidth-1:0] SvcRst = 13'h0095;

endpackage

// File: rtl/dc_sync.sv
// Multi-flop synchronizer with configurable depth, width and reset value.
module dc_sync #(
  parameter int unsigned           Stages   = 2,
  parameter int unsigned           Width    = 1,
  parameter logic [Width-1:0]      ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Stages-1:0][Width-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[Stages-2:0], d_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {Stages{ResetVal}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/dc_svc.sv
// Service status word generator: synchronizes async requests, latches events and bus
// timeouts, and presents them on pin_svc. Define DC_SVC_TOUT_EN for the internal timeout FSM.
module dc_svc
  import dc_svc_pkg::*;
#(
  parameter int unsigned TOUT_LIMIT  = 64,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                pin_clk,
  input  logic                pin_rst_n,
  input  logic                pin_mce_p,
  input  logic                pin_mce_n,
  input  logic [3:0]          pin_irq,
  input  logic                pin_evnt,
  input  logic                pin_aclo_n,
  input  logic                pin_dclo_n,
  input  logic                pin_halt,
  input  logic                pin_cce_n,
  input  logic                pin_abt_n,
  input  logic                pin_par_n,
  input  logic                pin_sync,
  input  logic                pin_rply,
  input  logic                pin_tout,
  input  logic                pin_evnt_clr,
  input  logic                pin_tout_clr,
  output logic [SvcWidth-1:0] pin_svc
);

  logic [3:0] irq_s;
  logic       evnt_s, aclo_n_s, dclo_n_s, halt_s;

  dc_sync #(.Stages(SYNC_STAGES), .Width(4), .ResetVal(4'h0)) u_sync_irq (
    .clk_i(pin_clk), .rst_ni(pin_rst_n), .d_i(pin_irq), .q_o(irq_s)
  );
  dc_sync #(.Stages(SYNC_STAGES), .Width(1), .ResetVal(1'b0)) u_sync_evnt (
    .clk_i(pin_clk), .rst_ni(pin_rst_n), .d_i(pin_evnt), .q_o(evnt_s)
  );
  dc_sync #(.Stages(SYNC_STAGES), .Width(1), .ResetVal(1'b1)) u_sync_aclo (
    .clk_i(pin_clk), .rst_ni(pin_rst_n), .d_i(pin_aclo_n), .q_o(aclo_n_s)
  );
  dc_sync #(.Stages(SYNC_STAGES), .Width(1), .ResetVal(1'b1)) u_sync_dclo (
    .clk_i(pin_clk), .rst_ni(pin_rst_n), .d_i(pin_dclo_n), .q_o(dclo_n_s)
  );
  dc_sync #(.Stages(SYNC_STAGES), .Width(1), .ResetVal(1'b0)) u_sync_halt (
    .clk_i(pin_clk), .rst_ni(pin_rst_n), .d_i(pin_halt), .q_o(halt_s)
  );

  // Edge detection stays disarmed until the synchronizer has flushed its reset value,
  // so an input already high at reset release is not mistaken for an event.
  localparam logic [2:0] WarmDone = 3'(SYNC_STAGES + 1);

  logic [2:0] warm_q, warm_d;
  logic       evnt_prev_q, evnt_prev_d;
  logic       evnt_q, evnt_d;
  logic       tout_q, tout_d;
  logic       tout_set;
  logic       armed;
  logic [SvcWidth-1:0] svc_q, svc_d;

  assign armed = (warm_q == WarmDone);

  always_comb begin
    warm_d      = armed ? warm_q : warm_q + 3'd1;
    evnt_prev_d = evnt_s;
    evnt_d      = evnt_q;
    if (armed && evnt_s && !evnt_prev_q) begin
      evnt_d = 1'b1;
    end else if (pin_evnt_clr && pin_mce_n) begin
      evnt_d = 1'b0;
    end
  end

`ifdef DC_SVC_TOUT_EN
  localparam logic [7:0] ToutLim = 8'(TOUT_LIMIT);

  tout_st_e   st_q, st_d;
  logic [7:0] cnt_q, cnt_d;
  logic       unused_tout;

  assign unused_tout = pin_tout;

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    tout_set = 1'b0;
    if (pin_mce_p) begin
      case (st_q)
        StIdle: begin
          if (pin_sync && !pin_rply) begin
            st_d  = StCount;
            cnt_d = 8'd1;
          end
        end
        StCount: begin
          if (pin_rply || !pin_sync) begin
            st_d = StIdle;
          end else begin
            if (cnt_q < ToutLim) cnt_d = cnt_q + 8'd1;
            // Expire on the tick that brings the count up to the limit.
            if (cnt_q >= ToutLim - 8'd1) begin
              st_d     = StExpired;
              tout_set = 1'b1;
            end
          end
        end
        StExpired: begin
          if (!pin_sync) st_d = StIdle;
        end
        default: st_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge pin_clk or negedge pin_rst_n) begin
    if (!pin_rst_n) begin
      st_q  <= StIdle;
      cnt_q <= 8'd0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_tout;

  assign unused_tout = ^{pin_mce_p, pin_sync, pin_rply};
  assign tout_set    = pin_tout;
`endif

  always_comb begin
    tout_d = tout_q;
    if (tout_set) begin
      tout_d = 1'b1;
    end else if (pin_tout_clr && pin_mce_n) begin
      tout_d = 1'b0;
    end
  end

  // Status word only moves on pin_mce_n so the consumer's pin_mce_p sample sees it settled.
  always_comb begin
    svc_d = svc_q;
    if (pin_mce_n) begin
      svc_d                   = '0;
      svc_d[SvcEvnt]          = evnt_q;
      svc_d[SvcIrqLo +: 4]    = irq_s;
      svc_d[SvcAclo]          = aclo_n_s;
      svc_d[SvcZero]          = 1'b0;
      svc_d[SvcHalt]          = halt_s;
      svc_d[SvcCce]           = pin_cce_n;
      svc_d[SvcAbt]           = pin_abt_n;
      svc_d[SvcPar]           = pin_par_n;
      svc_d[SvcTout]          = tout_q;
      svc_d[SvcDclo]          = dclo_n_s;
    end
  end

  always_ff @(posedge pin_clk or negedge pin_rst_n) begin
    if (!pin_rst_n) begin
      warm_q      <= 3'd0;
      evnt_prev_q <= 1'b0;
      evnt_q      <= 1'b0;
      tout_q      <= 1'b0;
      svc_q       <= SvcRst;
    end else begin
      warm_q      <= warm_d;
      evnt_prev_q <= evnt_prev_d;
      evnt_q      <= evnt_d;
      tout_q      <= tout_d;
      svc_q       <= svc_d;
    end
  end

  assign pin_svc = svc_q;

endmodule

// File: tb/tb_dc_svc.sv
// Directed self-checking bench for dc_svc; timeout scenarios follow DC_SVC_TOUT_EN.
module tb_dc_svc;

  logic        pin_clk = 1'b0;
  logic        pin_rst_n;
  logic        pin_mce_p, pin_mce_n;
  logic [3:0]  pin_irq;
  logic        pin_evnt, pin_aclo_n, pin_dclo_n, pin_halt;
  logic        pin_cce_n, pin_abt_n, pin_par_n;
  logic        pin_sync, pin_rply, pin_tout;
  logic        pin_evnt_clr, pin_tout_clr;
  logic [12:0] pin_svc;

  int n_checks = 0;
  int n_errors = 0;

  dc_svc #(.TOUT_LIMIT(64), .SYNC_STAGES(2)) dut (
    .pin_clk(pin_clk), .pin_rst_n(pin_rst_n),
    .pin_mce_p(pin_mce_p), .pin_mce_n(pin_mce_n),
    .pin_irq(pin_irq), .pin_evnt(pin_evnt),
    .pin_aclo_n(pin_aclo_n), .pin_dclo_n(pin_dclo_n), .pin_halt(pin_halt),
    .pin_cce_n(pin_cce_n), .pin_abt_n(pin_abt_n), .pin_par_n(pin_par_n),
    .pin_sync(pin_sync), .pin_rply(pin_rply), .pin_tout(pin_tout),
    .pin_evnt_clr(pin_evnt_clr), .pin_tout_clr(pin_tout_clr),
    .pin_svc(pin_svc)
  );

  always #5 pin_clk = ~pin_clk;

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge pin_clk);
  endtask

  task automatic mce_n_pulse();
    pin_mce_n = 1'b1;
    @(negedge pin_clk);
    pin_mce_n = 1'b0;
  endtask

  task automatic mce_p_ticks(input int n);
    pin_mce_p = 1'b1;
    repeat (n) @(negedge pin_clk);
    pin_mce_p = 1'b0;
  endtask

  initial begin
    pin_rst_n = 1'b0;
    pin_mce_p = 1'b0; pin_mce_n = 1'b0;
    pin_irq = 4'h0; pin_evnt = 1'b0; pin_aclo_n = 1'b1; pin_dclo_n = 1'b1; pin_halt = 1'b0;
    pin_cce_n = 1'b1; pin_abt_n = 1'b1; pin_par_n = 1'b1;
    pin_sync = 1'b0; pin_rply = 1'b0; pin_tout = 1'b0;
    pin_evnt_clr = 1'b0; pin_tout_clr = 1'b0;

    // Reset word and no false event on release with pin_evnt high
    clks(3);
    check("reset_word", pin_svc, 13'h0095);
    pin_evnt = 1'b1;
    clks(1);
    pin_rst_n = 1'b1;
    clks(6);
    mce_n_pulse();
    check("rst_no_evnt", {12'h0, pin_svc[12]}, 13'h0);
    check("idle_word", pin_svc, 13'h009D);

    // Event edge, hold until pin_mce_n, then set
    pin_evnt = 1'b0;
    clks(4);
    pin_evnt = 1'b1;
    clks(3);
    check("evnt_hold", {12'h0, pin_svc[12]}, 13'h0);
    mce_n_pulse();
    check("evnt_set", {12'h0, pin_svc[12]}, 13'h1);

    // Clear without pin_mce_n is ignored; qualified clear works
    pin_evnt_clr = 1'b1;
    clks(1);
    pin_evnt_clr = 1'b0;
    mce_n_pulse();
    check("evnt_clr_unqual", {12'h0, pin_svc[12]}, 13'h1);
    pin_evnt_clr = 1'b1; pin_mce_n = 1'b1;
    clks(1);
    pin_evnt_clr = 1'b0; pin_mce_n = 1'b0;
    mce_n_pulse();
    check("evnt_clr", {12'h0, pin_svc[12]}, 13'h0);

    // Clear coincident with a new synchronized edge: set wins
    pin_evnt = 1'b0;
    clks(4);
    pin_evnt = 1'b1;
    clks(2);
    pin_evnt_clr = 1'b1; pin_mce_n = 1'b1;
    clks(1);
    pin_evnt_clr = 1'b0; pin_mce_n = 1'b0;
    mce_n_pulse();
    check("evnt_tie", {12'h0, pin_svc[12]}, 13'h1);
    pin_evnt_clr = 1'b1; pin_mce_n = 1'b1;
    clks(1);
    pin_evnt_clr = 1'b0; pin_mce_n = 1'b0;
    mce_n_pulse();
    check("evnt_clr2", pin_svc, 13'h009D);

    // IRQ / aclo mapping
    pin_irq = 4'b1000; pin_aclo_n = 1'b0;
    clks(3);
    mce_n_pulse();
    check("irq_bits", {9'h0, pin_svc[11:8]}, 13'h8);
    check("aclo_bit", {12'h0, pin_svc[7]}, 13'h0);
    check("irq_word", pin_svc, 13'h081D);

    // Remaining bit positions
    pin_irq = 4'b0101; pin_aclo_n = 1'b1; pin_cce_n = 1'b0; pin_par_n = 1'b0; pin_dclo_n = 1'b0;
    clks(3);
    mce_n_pulse();
    check("mixed_word", pin_svc, 13'h0588);
    pin_irq = 4'h0; pin_cce_n = 1'b1; pin_par_n = 1'b1; pin_dclo_n = 1'b1; pin_abt_n = 1'b0;
    clks(3);
    mce_n_pulse();
    check("abt_word", pin_svc, 13'h0095);
    pin_abt_n = 1'b1;

    // pin_svc only moves on pin_mce_n
    pin_halt = 1'b1;
    clks(4);
    check("halt_hold_hi", {12'h0, pin_svc[5]}, 13'h0);
    mce_n_pulse();
    check("halt_set", pin_svc, 13'h00BD);
    pin_halt = 1'b0;
    clks(4);
    check("halt_hold_lo", {12'h0, pin_svc[5]}, 13'h1);
    mce_n_pulse();
    check("halt_clr", pin_svc, 13'h009D);

`ifdef DC_SVC_TOUT_EN
    // 64 ticks without reply -> timeout; 63 ticks is not enough
    pin_sync = 1'b1;
    mce_p_ticks(63);
    mce_n_pulse();
    check("tout_63", {12'h0, pin_svc[1]}, 13'h0);
    mce_p_ticks(1);
    mce_n_pulse();
    check("tout_64", {12'h0, pin_svc[1]}, 13'h1);
    pin_sync = 1'b0;
    mce_p_ticks(1);
    mce_n_pulse();
    check("tout_sticky", {12'h0, pin_svc[1]}, 13'h1);
    pin_tout_clr = 1'b1; pin_mce_n = 1'b1;
    clks(1);
    pin_tout_clr = 1'b0; pin_mce_n = 1'b0;
    mce_n_pulse();
    check("tout_clr", {12'h0, pin_svc[1]}, 13'h0);

    // Reply on tick 63 cancels the count
    pin_sync = 1'b1;
    mce_p_ticks(62);
    pin_rply = 1'b1;
    mce_p_ticks(1);
    pin_rply = 1'b0; pin_sync = 1'b0;
    mce_p_ticks(5);
    mce_n_pulse();
    check("tout_rply63", {12'h0, pin_svc[1]}, 13'h0);

    // Reset mid-count aborts without timeout
    pin_sync = 1'b1;
    mce_p_ticks(40);
    pin_rst_n = 1'b0;
    #1;
    check("tout_rst_word", pin_svc, 13'h0095);
    pin_sync = 1'b0;
    clks(1);
    pin_rst_n = 1'b1;
    pin_sync = 1'b1;
    mce_p_ticks(40);
    mce_n_pulse();
    check("tout_rst_abort", {12'h0, pin_svc[1]}, 13'h0);
    pin_sync = 1'b0;
    mce_p_ticks(1);
`else
    // External timeout input sets the latch; qualified clear, set wins a tie
    pin_tout = 1'b1;
    clks(1);
    pin_tout = 1'b0;
    mce_n_pulse();
    check("ext_tout_set", {12'h0, pin_svc[1]}, 13'h1);
    pin_tout = 1'b1; pin_tout_clr = 1'b1; pin_mce_n = 1'b1;
    clks(1);
    pin_tout = 1'b0; pin_tout_clr = 1'b0; pin_mce_n = 1'b0;
    mce_n_pulse();
    check("ext_tout_tie", {12'h0, pin_svc[1]}, 13'h1);
    pin_tout_clr = 1'b1;
    clks(1);
    pin_tout_clr = 1'b0;
    mce_n_pulse();
    check("ext_tout_unqual", {12'h0, pin_svc[1]}, 13'h1);
    pin_tout_clr = 1'b1; pin_mce_n = 1'b1;
    clks(1);
    pin_tout_clr = 1'b0; pin_mce_n = 1'b0;
    mce_n_pulse();
    check("ext_tout_clr", pin_svc, 13'h009D);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
